// File: rtl/class_input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// class_debounce_pkg
// Shared types and constants for the two-channel input debouncer.
//   db_state_e            : per-channel debounce state (DB_STABLE / DB_CHANGING)
//   DB_STABLE_CYCLES_DEF  : default number of consecutive differing samples
//   DB_MIN_STABLE_CYCLES  : smallest legal STABLE_CYCLES (checked at elaboration)
//   DB_MAX_STABLE_CYCLES  : largest legal STABLE_CYCLES (checked at elaboration)
// -----------------------------------------------------------------------------
package class_debounce_pkg;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_CHANGING = 1'b1
  } db_state_e;

  localparam int unsigned DB_STABLE_CYCLES_DEF = 4;
  localparam int unsigned DB_MIN_STABLE_CYCLES = 2;
  localparam int unsigned DB_MAX_STABLE_CYCLES = 65535;

endpackage : class_debounce_pkg

// File: rtl/class_input_debounce_if.sv
// -----------------------------------------------------------------------------
// class_input_debounce_if
// One debounce channel's signal bundle.
//   sw   : raw (bouncy) level into the channel
//   lvl  : debounced level
//   rise : one-cycle strobe, lvl went 0->1
//   fall : one-cycle strobe, lvl went 1->0
// Modports:
//   master : board/consumer side (drives sw, observes conditioned outputs)
//   slave  : debounce channel side (reads sw, drives conditioned outputs)
// -----------------------------------------------------------------------------
interface class_input_debounce_if;

  logic sw;
  logic lvl;
  logic rise;
  logic fall;

  modport master (output sw, input lvl, input rise, input fall);
  modport slave  (input sw, output lvl, output rise, output fall);

endinterface : class_input_debounce_if

// File: rtl/class_input_debounce_channel.sv
// -----------------------------------------------------------------------------
// class_debounce_channel
// Single debounce channel: optional 2-flop synchronizer, saturating-free
// counter, two-state FSM, registered level and rise/fall strobes.
// Optional feature macro: DEBOUNCE_SYNC_EN (adds a 2-flop synchronizer on
// the raw input; latency grows by 2 cycles).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ch    : class_input_debounce_if.slave (sw in; lvl/rise/fall out)
// -----------------------------------------------------------------------------
module class_debounce_channel
  import class_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  class_input_debounce_if.slave ch
);

  if ((STABLE_CYCLES < DB_MIN_STABLE_CYCLES) ||
      (STABLE_CYCLES > DB_MAX_STABLE_CYCLES)) begin : g_bad_cfg
    $error("class_debounce_channel: STABLE_CYCLES out of legal range");
  end

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  logic            w_s;
  logic [CNT_W-1:0] r_cnt;
  db_state_e       r_state;
  logic            r_out;
  logic            r_rise;
  logic            r_fall;

`ifdef DEBOUNCE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ch.sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = ch.sw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= DB_STABLE;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_out) begin
        // Sample agrees with output: any partial run was a glitch.
        r_cnt   <= '0;
        r_state <= DB_STABLE;
      end else if (r_cnt == LP_CNT_LAST) begin
        r_out   <= w_s;
        r_cnt   <= '0;
        r_state <= DB_STABLE;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        // Counter is always 0 in DB_STABLE, so the first differing sample
        // loads 1 directly; later samples increment.
        r_cnt   <= (r_state == DB_STABLE) ? LP_CNT_ONE : (r_cnt + LP_CNT_ONE);
        r_state <= DB_CHANGING;
      end
    end
  end

  assign ch.lvl  = r_out;
  assign ch.rise = r_rise;
  assign ch.fall = r_fall;

endmodule : class_debounce_channel

// File: rtl/class_input_debounce.sv
// -----------------------------------------------------------------------------
// class_input_debounce
// Two independent debounce channels feeding the lab AND gate inputs.
// Wiring only; all logic lives in class_debounce_channel.
// Optional feature macro: DEBOUNCE_SYNC_EN (2-flop input synchronizers).
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   sw_a, sw_b     : raw switch/button levels
//   a, b           : debounced levels
//   a_rise, a_fall : one-cycle strobes on a transitions
//   b_rise, b_fall : one-cycle strobes on b transitions
// -----------------------------------------------------------------------------
module class_input_debounce
  import class_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a,
  input  logic sw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  class_input_debounce_if w_ch_a ();
  class_input_debounce_if w_ch_b ();

  assign w_ch_a.sw = sw_a;
  assign w_ch_b.sw = sw_b;

  class_debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ch_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ch    (w_ch_a.slave)
  );

  class_debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ch_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ch    (w_ch_b.slave)
  );

  assign a      = w_ch_a.lvl;
  assign a_rise = w_ch_a.rise;
  assign a_fall = w_ch_a.fall;
  assign b      = w_ch_b.lvl;
  assign b_rise = w_ch_b.rise;
  assign b_fall = w_ch_b.fall;

endmodule : class_input_debounce

// File: tb/tb_class_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_class_input_debounce
// Directed bench for class_input_debounce with STABLE_CYCLES=4.
// Expected latency is 4 edges, or 6 when DEBOUNCE_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_class_input_debounce;

`ifdef DEBOUNCE_SYNC_EN
  localparam int unsigned LAT = 6;
`else
  localparam int unsigned LAT = 4;
`endif

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  class_input_debounce_if u_if_a ();
  class_input_debounce_if u_if_b ();

  class_input_debounce #(
    .STABLE_CYCLES (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_a   (u_if_a.sw),
    .sw_b   (u_if_b.sw),
    .a      (u_if_a.lvl),
    .b      (u_if_b.lvl),
    .a_rise (u_if_a.rise),
    .a_fall (u_if_a.fall),
    .b_rise (u_if_b.rise),
    .b_fall (u_if_b.fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    checks   = 0;
    failures = 0;
    pat      = 8'b1111_0111;   // index 0 first: 1,1,1,0,1,1,1,1

    // Reset with both inputs high
    rst_n     = 1'b0;
    u_if_a.sw = 1'b1;
    u_if_b.sw = 1'b1;
    repeat (3) tick();
    check("rst_a",      u_if_a.lvl,  1'b0);
    check("rst_b",      u_if_b.lvl,  1'b0);
    check("rst_a_rise", u_if_a.rise, 1'b0);
    check("rst_a_fall", u_if_a.fall, 1'b0);
    check("rst_b_rise", u_if_b.rise, 1'b0);
    check("rst_b_fall", u_if_b.fall, 1'b0);
    rst_n = 1'b1;
    for (int unsigned i = 1; i < LAT; i++) begin
      tick();
      check("rel_a_wait", u_if_a.lvl, 1'b0);
      check("rel_b_wait", u_if_b.lvl, 1'b0);
    end
    tick();
    check("rel_a",      u_if_a.lvl,  1'b1);
    check("rel_b",      u_if_b.lvl,  1'b1);
    check("rel_a_rise", u_if_a.rise, 1'b1);
    check("rel_b_rise", u_if_b.rise, 1'b1);
    tick();
    check("rel_a_rise_end", u_if_a.rise, 1'b0);
    check("rel_b_rise_end", u_if_b.rise, 1'b0);
    check("rel_a_hold",     u_if_a.lvl,  1'b1);

    // Simultaneous fall
    u_if_a.sw = 1'b0;
    u_if_b.sw = 1'b0;
    for (int unsigned i = 1; i < LAT; i++) begin
      tick();
      check("sfall_a_wait", u_if_a.lvl, 1'b1);
      check("sfall_b_wait", u_if_b.lvl, 1'b1);
    end
    tick();
    check("sfall_a",      u_if_a.lvl,  1'b0);
    check("sfall_b",      u_if_b.lvl,  1'b0);
    check("sfall_a_fall", u_if_a.fall, 1'b1);
    check("sfall_b_fall", u_if_b.fall, 1'b1);
    check("sfall_a_rise", u_if_a.rise, 1'b0);
    tick();
    check("sfall_a_fall_end", u_if_a.fall, 1'b0);
    check("sfall_b_fall_end", u_if_b.fall, 1'b0);

    // Clean step on A only
    u_if_a.sw = 1'b1;
    for (int unsigned i = 1; i < LAT; i++) begin
      tick();
      check("step_a_wait", u_if_a.lvl, 1'b0);
    end
    tick();
    check("step_a",      u_if_a.lvl,  1'b1);
    check("step_a_rise", u_if_a.rise, 1'b1);
    check("step_a_fall", u_if_a.fall, 1'b0);
    check("step_b",      u_if_b.lvl,  1'b0);
    check("step_b_rise", u_if_b.rise, 1'b0);
    check("step_b_fall", u_if_b.fall, 1'b0);
    tick();
    check("step_a_rise_end", u_if_a.rise, 1'b0);
    check("step_a_hold",     u_if_a.lvl,  1'b1);

    // Return A to 0
    u_if_a.sw = 1'b0;
    repeat (LAT) tick();
    check("ret_a_fall", u_if_a.fall, 1'b1);
    tick();
    check("ret_a", u_if_a.lvl, 1'b0);

    // Bounce: 3-sample run is rejected, rise on the 4th of the final run
    for (int unsigned i = 0; i <= 7 + LAT - 4; i++) begin
      u_if_a.sw = (i < 8) ? pat[i] : 1'b1;
      tick();
      check("bounce_a",      u_if_a.lvl,  (i == 7 + LAT - 4) ? 1'b1 : 1'b0);
      check("bounce_a_rise", u_if_a.rise, (i == 7 + LAT - 4) ? 1'b1 : 1'b0);
    end

    // Reset mid-count on B
    u_if_a.sw = 1'b0;
    repeat (LAT + 1) tick();
    check("mid_pre_a", u_if_a.lvl, 1'b0);
    u_if_b.sw = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_b",      u_if_b.lvl,  1'b0);
    check("mid_rst_b_rise", u_if_b.rise, 1'b0);
    #1 rst_n = 1'b1;
    for (int unsigned i = 1; i < LAT; i++) begin
      tick();
      check("mid_b_wait", u_if_b.lvl, 1'b0);
    end
    tick();
    check("mid_b",      u_if_b.lvl,  1'b1);
    check("mid_b_rise", u_if_b.rise, 1'b1);
    check("mid_b_fall", u_if_b.fall, 1'b0);
    check("mid_a",      u_if_a.lvl,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_class_input_debounce

// File: doc/class_input_debounce.md
# class_input_debounce

Two-channel input conditioning stage directly upstream of the lab AND gate. Raw board switch/button levels `sw_a` and `sw_b` are debounced independently. Clean levels `a` and `b` drive the gate's `a`/`b` inputs, and single-cycle rise/fall strobes are produced for LEDs and counters. Both channels share one clock and one reset.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive differing samples required before an output flips; legal range 2..65535.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: width of the per-channel counter; derived, never overridden.

Ports:
- `clk` input 1: single clock; every flop is rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `sw_a` input 1: raw, bouncy, possibly asynchronous level, channel A.
- `sw_b` input 1: raw level, channel B.
- `a` output 1: debounced level A; feeds the AND gate's `a`.
- `b` output 1: debounced level B; feeds the AND gate's `b`.
- `a_rise`, `a_fall` output 1: one-cycle strobes on `a` transitions.
- `b_rise`, `b_fall` output 1: one-cycle strobes on `b` transitions.

## Operation
- Channels are identical and fully independent; the description below is per channel.
- Sample `s`: the raw input, or the synchronizer output when `DEBOUNCE_SYNC_EN` is defined.
- State machine, two states:
  - STABLE: `s == out`, counter is 0.
  - CHANGING: `s != out`, counter is counting.
- At each rising edge:
  - If `s == out`: counter <= 0, state <= STABLE. A glitch shorter than STABLE_CYCLES is discarded here.
  - Else, if counter == STABLE_CYCLES-1: `out` <= `s`, counter <= 0, state <= STABLE. The matching rise/fall strobe is asserted.
  - Else: counter <= counter+1, state <= CHANGING.
- Strobes are registered and are high for exactly one cycle, aligned with the first cycle `out` shows its new value. Rise and fall are never high together.
- The counter never exceeds STABLE_CYCLES-1. There is no wrap-around.
- The block holds no combinational path from input to output.

## Timing
- Reset values: `a`, `b` = 0; all strobes = 0; counters = 0; state = STABLE; synchronizer flops = 0.
- Reset is asserted asynchronously and takes effect immediately, even mid-count. It is released synchronously through the flops' normal edge behaviour. The first sample is taken at the first rising edge with `rst_n` high.
- Latency without the synchronizer: the raw input is first sampled differing at edge k and stays differing. `out` changes at edge k+STABLE_CYCLES-1, which is STABLE_CYCLES samples in total.
- With the synchronizer, add 2 cycles.
- A raw input that is already 1 during reset appears on the output STABLE_CYCLES (+2) edges after release, with a rise strobe.
- Simultaneous transitions on A and B are handled in the same cycle. There is no arbitration.

## Configuration
- `DEBOUNCE_SYNC_EN` defined:
  - Each raw input passes through a 2-flop synchronizer, reset to 0, before the debounce logic.
  - Latency is STABLE_CYCLES+2.
  - Required for real switch pins.
- `DEBOUNCE_SYNC_EN` undefined:
  - The raw inputs are sampled directly.
  - Latency is STABLE_CYCLES.
  - Intended for simulation and for inputs that are already synchronous.

## Structure
- Package `class_debounce_pkg` holds:
  - the state enum (`DB_STABLE`, `DB_CHANGING`);
  - the default-STABLE_CYCLES constant;
  - the minimum-legal-STABLE_CYCLES constant, which is checked by an elaboration assertion.
- One sub-module, `class_debounce_channel`:
  - contains the optional synchronizer, counter, state, level and strobes;
  - is instantiated twice, for A and B;
  - the top is wiring only.

## Test plan
All scenarios use STABLE_CYCLES=4, with `DEBOUNCE_SYNC_EN` undefined unless noted.
- Reset: hold `rst_n`=0 with `sw_a`=`sw_b`=1 -> all outputs 0. Release -> `a`=`b`=1 with `a_rise`=`b_rise`=1 for one cycle, 4 edges after release.
- Clean step: `sw_a` 0->1 and held -> `a` rises exactly 4 edges later, `a_rise` is high for one cycle, and `b`, `b_rise`, `b_fall` stay 0.
- Bounce: `sw_a` pattern 1,1,1,0,1,1,1,1 on successive edges -> the 3-cycle run is rejected, and `a` rises only after the final 4 consecutive 1s.
- Simultaneous fall: `a`=`b`=1, both inputs drop together -> `a_fall` and `b_fall` assert in the same cycle, 4 edges later.
- Reset mid-count: `sw_b` high for 2 edges, then `rst_n` pulsed low between edges -> `b` stays 0 and the counter clears. After release, a full 4 fresh samples are needed.
- Sync on: define `DEBOUNCE_SYNC_EN` and repeat the clean-step scenario -> `a` rises 6 edges after the input change.
